// File: rtl/mips_decode_ext_if.sv
// Decoder bus: instruction fields and load data in, datapath controls and extended values out.
//   master : the datapath side; drives opcode/funct/zero/imm16/ld_byte/ld_half
//   slave  : the decoder; drives imm32/byte_ext/half_ext, all control lines and illegal
interface mips_decode_ext_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic [15:0] imm16;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  logic [31:0] imm32;
  logic [31:0] byte_ext;
  logic [31:0] half_ext;
  logic        RegDst;
  logic        MemRead;
  logic        MemtoReg;
  logic        MemWrite;
  logic        ALUSrc;
  logic        RegWrite;
  logic        EXTOP;
  logic [3:0]  ALUOp;
  logic [1:0]  NPCOP;
  logic        ShiftIndex;
  logic        ShiftDirection;
  logic        SArith;
  logic        ALUasrc;
  logic        call;
  logic        SpLoad;
  logic        BorH;
  logic        SorU;
  logic        SpecialIn;
  logic        DMemBorH;
  logic        illegal;

  modport master (
    output opcode, funct, zero, imm16, ld_byte, ld_half,
    input  imm32, byte_ext, half_ext, RegDst, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite,
           EXTOP, ALUOp, NPCOP, ShiftIndex, ShiftDirection, SArith, ALUasrc, call, SpLoad,
           BorH, SorU, SpecialIn, DMemBorH, illegal
  );

  modport slave (
    input  opcode, funct, zero, imm16, ld_byte, ld_half,
    output imm32, byte_ext, half_ext, RegDst, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite,
           EXTOP, ALUOp, NPCOP, ShiftIndex, ShiftDirection, SArith, ALUasrc, call, SpLoad,
           BorH, SorU, SpecialIn, DMemBorH, illegal
  );
endinterface

// File: rtl/mips_decode_ext.sv
// Single-cycle MIPS main decoder with immediate and load-data extenders.
//   clk : clocks only the sticky illegal-instruction flag
//   rst : asynchronous active-high reset; clears illegal and masks state-changing controls
//   bus : mips_decode_ext_if.slave; instruction fields in, controls/extended data out
// Everything except illegal is combinational from the bus inputs.
module mips_decode_ext (
  input logic              clk,
  input logic              rst,
  mips_decode_ext_if.slave bus
);

  localparam logic [3:0] AluNop   = 4'b0000;
  localparam logic [3:0] AluAdd   = 4'b0001;
  localparam logic [3:0] AluSub   = 4'b0010;
  localparam logic [3:0] AluAnd   = 4'b0011;
  localparam logic [3:0] AluOr    = 4'b0100;
  localparam logic [3:0] AluXor   = 4'b0101;
  localparam logic [3:0] AluNor   = 4'b0110;
  localparam logic [3:0] AluSlt   = 4'b0111;
  localparam logic [3:0] AluSltu  = 4'b1000;
  localparam logic [3:0] AluLui   = 4'b1001;
  localparam logic [3:0] AluPassA = 4'b1010;

  typedef struct packed {
    logic       reg_dst;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       extop;
    logic [3:0] alu_op;
    logic [1:0] npcop;
    logic       shift_index;
    logic       shift_dir;
    logic       sarith;
    logic       alu_asrc;
    logic       call;
    logic       sp_load;
    logic       borh;
    logic       soru;
    logic       special_in;
    logic       dmem_borh;
  } ctrl_t;

  ctrl_t c;
  logic  legal;
  logic  illegal_q;

  always_comb begin
    c     = '0;
    legal = 1'b1;
    unique case (bus.opcode)
      6'h00: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        case (bus.funct)
          6'h20, 6'h21: c.alu_op = AluAdd;
          6'h22, 6'h23: c.alu_op = AluSub;
          6'h24:        c.alu_op = AluAnd;
          6'h25:        c.alu_op = AluOr;
          6'h26:        c.alu_op = AluXor;
          6'h27:        c.alu_op = AluNor;
          6'h2A:        c.alu_op = AluSlt;
          6'h2B:        c.alu_op = AluSltu;
          // Shifts: shifter result is routed into ALU A and passed through.
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: begin
            c.alu_asrc    = 1'b1;
            c.alu_op      = AluPassA;
            c.shift_index = bus.funct[2];
            c.shift_dir   = bus.funct[1];
            c.sarith      = bus.funct[0];
          end
          6'h08: begin
            c.npcop     = 2'b11;
            c.reg_write = 1'b0;
          end
          6'h09: begin
            c.npcop = 2'b11;
            c.call  = 1'b1;
          end
          default: legal = 1'b0;
        endcase
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.extop     = (bus.opcode[2] == 1'b0);  // arithmetic/compare sign-extend
        case (bus.opcode[2:0])
          3'd0, 3'd1: c.alu_op = AluAdd;
          3'd2:       c.alu_op = AluSlt;
          3'd3:       c.alu_op = AluSltu;
          3'd4:       c.alu_op = AluAnd;
          3'd5:       c.alu_op = AluOr;
          3'd6:       c.alu_op = AluXor;
          default:    c.alu_op = AluLui;
        endcase
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        c.alu_src    = 1'b1;
        c.alu_op     = AluAdd;
        c.extop      = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        if (bus.opcode != 6'h23) begin
          c.sp_load = 1'b1;
          c.borh    = bus.opcode[0];
          c.soru    = ~bus.opcode[2];
        end
      end
      6'h28, 6'h29, 6'h2B: begin
        c.alu_src   = 1'b1;
        c.alu_op    = AluAdd;
        c.extop     = 1'b1;
        c.mem_write = 1'b1;
        if (bus.opcode != 6'h2B) begin
          c.special_in = 1'b1;
          c.dmem_borh  = bus.opcode[0];
        end
      end
      6'h04, 6'h05: begin
        c.alu_op = AluSub;
        c.extop  = 1'b1;
        // beq takes on zero, bne on non-zero.
        c.npcop  = ((bus.opcode[0] ^ bus.zero) == 1'b1) ? 2'b01 : 2'b00;
      end
      6'h02: c.npcop = 2'b10;
      6'h03: begin
        c.npcop     = 2'b10;
        c.call      = 1'b1;
        c.reg_write = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      c        = '0;
      c.alu_op = AluNop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (!legal) begin
      illegal_q <= 1'b1;
    end
  end

  always_comb begin
    bus.RegDst         = c.reg_dst;
    bus.MemtoReg       = c.mem_to_reg;
    bus.ALUSrc         = c.alu_src;
    bus.EXTOP          = c.extop;
    bus.ALUOp          = c.alu_op;
    bus.ShiftIndex     = c.shift_index;
    bus.ShiftDirection = c.shift_dir;
    bus.SArith         = c.sarith;
    bus.ALUasrc        = c.alu_asrc;
    bus.call           = c.call;
    bus.SpLoad         = c.sp_load;
    bus.BorH           = c.borh;
    bus.SorU           = c.soru;
    bus.SpecialIn      = c.special_in;
    bus.DMemBorH       = c.dmem_borh;
    // Reset masks anything that could change architectural state.
    bus.RegWrite       = c.reg_write & ~rst;
    bus.MemWrite       = c.mem_write & ~rst;
    bus.MemRead        = c.mem_read & ~rst;
    bus.NPCOP          = rst ? 2'b00 : c.npcop;
    bus.illegal        = illegal_q;
    bus.imm32    = c.extop ? {{16{bus.imm16[15]}}, bus.imm16} : {16'h0000, bus.imm16};
    bus.byte_ext = c.soru ? {{24{bus.ld_byte[7]}}, bus.ld_byte} : {24'h000000, bus.ld_byte};
    bus.half_ext = c.soru ? {{16{bus.ld_half[15]}}, bus.ld_half} : {16'h0000, bus.ld_half};
  end

endmodule

// File: tb/tb_mips_decode_ext.sv
module tb_mips_decode_ext;

  typedef struct packed {
    logic       reg_dst;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       extop;
    logic [3:0] alu_op;
    logic [1:0] npcop;
    logic       shift_index;
    logic       shift_dir;
    logic       sarith;
    logic       alu_asrc;
    logic       call;
    logic       sp_load;
    logic       borh;
    logic       soru;
    logic       special_in;
    logic       dmem_borh;
  } ctl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  mips_decode_ext_if bus ();

  mips_decode_ext u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  ctl_t got;
  always_comb begin
    got = {bus.RegDst, bus.MemRead, bus.MemtoReg, bus.MemWrite, bus.ALUSrc, bus.RegWrite,
           bus.EXTOP, bus.ALUOp, bus.NPCOP, bus.ShiftIndex, bus.ShiftDirection, bus.SArith,
           bus.ALUasrc, bus.call, bus.SpLoad, bus.BorH, bus.SorU, bus.SpecialIn, bus.DMemBorH};
  end

  int n_pass = 0;
  int n_total = 0;

  // Reference tables: one entry per instruction, built from the instruction list.
  ctl_t op_tab[64];
  bit   op_ok[64];
  ctl_t fn_tab[64];
  bit   fn_ok[64];
  bit   ill_m;

  function automatic ctl_t r_alu(input logic [3:0] op);
    ctl_t c = '0;
    c.reg_dst = 1; c.reg_write = 1; c.alu_op = op;
    return c;
  endfunction

  function automatic ctl_t r_shift(input bit by_rs, input bit right, input bit arith);
    ctl_t c = r_alu(4'b1010);
    c.alu_asrc = 1; c.shift_index = by_rs; c.shift_dir = right; c.sarith = arith;
    return c;
  endfunction

  function automatic ctl_t i_alu(input logic [3:0] op, input bit sext);
    ctl_t c = '0;
    c.alu_src = 1; c.reg_write = 1; c.alu_op = op; c.extop = sext;
    return c;
  endfunction

  function automatic ctl_t ld(input bit partial, input bit half, input bit signed_ld);
    ctl_t c = i_alu(4'b0001, 1);
    c.mem_read = 1; c.mem_to_reg = 1; c.sp_load = partial; c.borh = half; c.soru = signed_ld;
    return c;
  endfunction

  function automatic ctl_t st(input bit partial, input bit half);
    ctl_t c = '0;
    c.alu_src = 1; c.alu_op = 4'b0001; c.extop = 1; c.mem_write = 1;
    c.special_in = partial; c.dmem_borh = half;
    return c;
  endfunction

  task automatic build_tables();
    ctl_t c;
    for (int i = 0; i < 64; i++) begin
      op_ok[i] = 0; fn_ok[i] = 0; op_tab[i] = '0; fn_tab[i] = '0;
    end
    fn_tab[6'h20] = r_alu(4'b0001); fn_tab[6'h21] = r_alu(4'b0001);
    fn_tab[6'h22] = r_alu(4'b0010); fn_tab[6'h23] = r_alu(4'b0010);
    fn_tab[6'h24] = r_alu(4'b0011); fn_tab[6'h25] = r_alu(4'b0100);
    fn_tab[6'h26] = r_alu(4'b0101); fn_tab[6'h27] = r_alu(4'b0110);
    fn_tab[6'h2A] = r_alu(4'b0111); fn_tab[6'h2B] = r_alu(4'b1000);
    fn_tab[6'h00] = r_shift(0, 0, 0); fn_tab[6'h02] = r_shift(0, 1, 0);
    fn_tab[6'h03] = r_shift(0, 1, 1); fn_tab[6'h04] = r_shift(1, 0, 0);
    fn_tab[6'h06] = r_shift(1, 1, 0); fn_tab[6'h07] = r_shift(1, 1, 1);
    c = r_alu(4'b0000); c.npcop = 2'b11; c.reg_write = 0; fn_tab[6'h08] = c;
    c = r_alu(4'b0000); c.npcop = 2'b11; c.call = 1;      fn_tab[6'h09] = c;
    foreach (fn_ok[i]) fn_ok[i] = (fn_tab[i] != '0);
    op_ok[0] = 1;
    op_tab[6'h08] = i_alu(4'b0001, 1); op_tab[6'h09] = i_alu(4'b0001, 1);
    op_tab[6'h0A] = i_alu(4'b0111, 1); op_tab[6'h0B] = i_alu(4'b1000, 1);
    op_tab[6'h0C] = i_alu(4'b0011, 0); op_tab[6'h0D] = i_alu(4'b0100, 0);
    op_tab[6'h0E] = i_alu(4'b0101, 0); op_tab[6'h0F] = i_alu(4'b1001, 0);
    op_tab[6'h23] = ld(0, 0, 0);
    op_tab[6'h20] = ld(1, 0, 1); op_tab[6'h24] = ld(1, 0, 0);
    op_tab[6'h21] = ld(1, 1, 1); op_tab[6'h25] = ld(1, 1, 0);
    op_tab[6'h2B] = st(0, 0); op_tab[6'h28] = st(1, 0); op_tab[6'h29] = st(1, 1);
    c = '0; c.alu_op = 4'b0010; c.extop = 1; op_tab[6'h04] = c; op_tab[6'h05] = c;
    c = '0; c.npcop = 2'b10; op_tab[6'h02] = c;
    c.call = 1; c.reg_write = 1; op_tab[6'h03] = c;
    for (int i = 1; i < 64; i++) op_ok[i] = (op_tab[i] != '0);
  endtask

  function automatic ctl_t model(input logic [5:0] op, input logic [5:0] fn, input bit z,
                                 input bit r, output bit legal);
    ctl_t c;
    if (op == 6'h00) begin
      legal = fn_ok[fn]; c = fn_tab[fn];
    end else begin
      legal = op_ok[op]; c = op_tab[op];
      if ((op == 6'h04 && z) || (op == 6'h05 && !z)) c.npcop = 2'b01;
    end
    if (!legal) c = '0;
    if (r) begin
      c.reg_write = 0; c.mem_write = 0; c.mem_read = 0; c.npcop = 2'b00;
    end
    return c;
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] v, input int bits, input bit sgn);
    if (sgn && v >= (32'd1 << (bits - 1))) return v - (32'd1 << bits);
    return v;
  endfunction

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input bit z,
                       input logic [15:0] imm, input logic [7:0] b, input logic [15:0] h);
    @(negedge clk);
    bus.opcode = op; bus.funct = fn; bus.zero = z; bus.imm16 = imm;
    bus.ld_byte = b; bus.ld_half = h;
    #1;
  endtask

  task automatic test_reset();
    ctl_t exp;
    bit lg;
    rst = 1'b1;
    drive(6'h23, 6'h00, 1'b0, 16'h0000, 8'h00, 16'h0000);
    exp = model(6'h23, 6'h00, 1'b0, 1'b1, lg);
    n_total++;
    if (got !== exp) $display("FAIL reset_lw_ctrl got=%h exp=%h", got, exp);
    else n_pass++;
    n_total++;
    if (bus.illegal !== 1'b0) $display("FAIL reset_illegal got=%b exp=0", bus.illegal);
    else n_pass++;
    // Illegal opcode under reset must not set the flag at a clock edge.
    drive(6'h3F, 6'h00, 1'b0, 16'h0000, 8'h00, 16'h0000);
    @(posedge clk); #1;
    n_total++;
    if (bus.illegal !== 1'b0) $display("FAIL reset_blocks_illegal got=%b exp=0", bus.illegal);
    else n_pass++;
    drive(6'h00, 6'h20, 1'b0, 16'h0000, 8'h00, 16'h0000);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    ctl_t exp;
    bit lg;
    drive(6'h00, 6'h20, 1'b0, 16'h1234, 8'h00, 16'h0000);
    n_total++;
    if (got.reg_dst !== 1 || got.reg_write !== 1 || got.alu_op !== 4'b0001 || got.npcop !== 0)
      $display("FAIL add_fields got=%h", got);
    else n_pass++;
    drive(6'h00, 6'h03, 1'b0, 16'h0000, 8'h00, 16'h0000);
    n_total++;
    if (got.alu_asrc !== 1 || got.shift_dir !== 1 || got.sarith !== 1 || got.alu_op !== 4'b1010)
      $display("FAIL sra_fields got=%h", got);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      drive((k < 2) ? 6'h04 : 6'h05, 6'h00, k[0], 16'h0010, 8'h00, 16'h0000);
      n_total++;
      if (got.npcop !== ((k == 1 || k == 2) ? 2'b01 : 2'b00) || got.reg_write !== 0)
        $display("FAIL branch_%0d npcop=%b regwrite=%b", k, got.npcop, got.reg_write);
      else n_pass++;
    end
    drive(6'h0D, 6'h00, 1'b0, 16'h8000, 8'h00, 16'h0000);
    n_total++;
    if (bus.imm32 !== 32'h00008000) $display("FAIL ori_imm got=%h exp=00008000", bus.imm32);
    else n_pass++;
    drive(6'h08, 6'h00, 1'b0, 16'h8000, 8'h00, 16'h0000);
    n_total++;
    if (bus.imm32 !== 32'hFFFF8000) $display("FAIL addi_imm got=%h exp=FFFF8000", bus.imm32);
    else n_pass++;
    drive(6'h20, 6'h00, 1'b0, 16'h0000, 8'h80, 16'h0000);
    n_total++;
    if (bus.byte_ext !== 32'hFFFFFF80 || got.sp_load !== 1 || got.borh !== 0)
      $display("FAIL lb byte_ext=%h splload=%b borh=%b", bus.byte_ext, got.sp_load, got.borh);
    else n_pass++;
    drive(6'h25, 6'h00, 1'b0, 16'h0000, 8'h00, 16'h8001);
    n_total++;
    if (bus.half_ext !== 32'h00008001) $display("FAIL lhu_half got=%h exp=00008001", bus.half_ext);
    else n_pass++;
    drive(6'h03, 6'h00, 1'b0, 16'h0000, 8'h00, 16'h0000);
    n_total++;
    if (got.call !== 1 || got.npcop !== 2'b10 || got.reg_write !== 1)
      $display("FAIL jal got=%h", got);
    else n_pass++;
    drive(6'h29, 6'h00, 1'b0, 16'h0000, 8'h00, 16'h0000);
    n_total++;
    if (got.mem_write !== 1 || got.special_in !== 1 || got.dmem_borh !== 1)
      $display("FAIL sh got=%h", got);
    else n_pass++;
    // Sweep every legal R-type funct and opcode against the tables.
    for (int i = 0; i < 64; i++) begin
      if (fn_ok[i]) begin
        drive(6'h00, i[5:0], 1'b1, 16'h0000, 8'h00, 16'h0000);
        exp = model(6'h00, i[5:0], 1'b1, 1'b0, lg);
        n_total++;
        if (got !== exp) $display("FAIL sweep_fn_%h got=%h exp=%h", i, got, exp);
        else n_pass++;
      end
      if (op_ok[i] && i != 0) begin
        drive(i[5:0], 6'h3F, 1'b1, 16'h0000, 8'h00, 16'h0000);
        exp = model(i[5:0], 6'h3F, 1'b1, 1'b0, lg);
        n_total++;
        if (got !== exp) $display("FAIL sweep_op_%h got=%h exp=%h", i, got, exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_illegal_sticky();
    drive(6'h3F, 6'h00, 1'b0, 16'h0000, 8'h00, 16'h0000);
    n_total++;
    if (got !== '0) $display("FAIL illegal_ctrl got=%h exp=0", got);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (bus.illegal !== 1'b1) $display("FAIL illegal_set got=%b exp=1", bus.illegal);
    else n_pass++;
    drive(6'h23, 6'h00, 1'b0, 16'h0000, 8'h00, 16'h0000);
    @(posedge clk); #1;
    n_total++;
    if (bus.illegal !== 1'b1) $display("FAIL illegal_held got=%b exp=1", bus.illegal);
    else n_pass++;
    // Asynchronous reset mid-cycle, away from any clock edge.
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    n_total++;
    if (bus.illegal !== 1'b0 || bus.RegWrite !== 1'b0 || bus.MemRead !== 1'b0)
      $display("FAIL async_rst illegal=%b regwrite=%b memread=%b",
               bus.illegal, bus.RegWrite, bus.MemRead);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++;
    if (bus.RegWrite !== 1'b1) $display("FAIL rst_release_regwrite got=%b exp=1", bus.RegWrite);
    else n_pass++;
    ill_m = 0;
  endtask

  task automatic test_random();
    ctl_t exp;
    bit lg;
    logic [5:0] op, fn;
    logic [15:0] imm, h;
    logic [7:0] b;
    bit z;
    for (int i = 0; i < 300; i++) begin
      op  = (($urandom % 3) == 0) ? 6'h00 : 6'($urandom);
      fn  = 6'($urandom);
      z   = 1'($urandom);
      imm = 16'($urandom);
      b   = 8'($urandom);
      h   = 16'($urandom);
      drive(op, fn, z, imm, b, h);
      exp = model(op, fn, z, 1'b0, lg);
      n_total++;
      if (got !== exp) $display("FAIL rnd_ctrl op=%h fn=%h got=%h exp=%h", op, fn, got, exp);
      else n_pass++;
      n_total++;
      if (bus.imm32 !== ext({16'h0, imm}, 16, exp.extop) ||
          bus.byte_ext !== ext({24'h0, b}, 8, exp.soru) ||
          bus.half_ext !== ext({16'h0, h}, 16, exp.soru))
        $display("FAIL rnd_ext op=%h imm32=%h byte=%h half=%h", op, bus.imm32, bus.byte_ext,
                 bus.half_ext);
      else n_pass++;
      @(posedge clk); #1;
      if (!lg) ill_m = 1;
      n_total++;
      if (bus.illegal !== ill_m) $display("FAIL rnd_illegal got=%b exp=%b", bus.illegal, ill_m);
      else n_pass++;
    end
  endtask

  initial begin
    bus.opcode = '0; bus.funct = '0; bus.zero = 0; bus.imm16 = '0;
    bus.ld_byte = '0; bus.ld_half = '0;
    ill_m = 0;
    build_tables();
    test_reset();
    test_directed();
    test_illegal_sticky();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
